// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with interrupt entry and MRET return sequencing
// for the single-cycle RV32I core.
module csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic        i_csr_rd_en,
  input  logic        i_csr_wr_en,
  input  logic [1:0]  i_csr_op,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  output logic        o_illegal_csr,
  input  logic        i_is_mret,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_next_pc,
  input  logic        i_timer_irq,
  input  logic        i_ext_irq,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush
);
  typedef enum logic [1:0] {RUN, TRAP, RET} state_t;
  state_t      r_state, w_state_nxt;
  logic        r_mie, r_mpie, r_mtie, r_meie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0] r_mcycle;
  logic [31:0] w_old, w_new, w_vec;
  logic        w_hit, w_run, w_we, w_mret, w_ext, w_irq, w_take;
  logic [3:0]  w_code;
  logic        w_unused;

  assign w_unused = ^i_pc;
  assign w_run    = r_state == RUN;

  always_comb begin
    w_old = '0;
    w_hit = 1'b1;
    case (i_csr_addr)
      12'h300: w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      12'h304: w_old = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h344: w_old = {20'b0, i_ext_irq, 3'b0, i_timer_irq, 7'b0};
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hF14: w_old = HART_ID;
      default: w_hit = 1'b0;
    endcase
  end

  assign o_csr_rdata   = (w_run & i_csr_rd_en) ? w_old : '0;
  assign o_illegal_csr = w_run & (i_csr_rd_en | i_csr_wr_en) & ~w_hit;
  assign w_new  = i_csr_op == 2'b01 ? i_csr_wdata :
                  i_csr_op == 2'b10 ? (w_old | i_csr_wdata) : (w_old & ~i_csr_wdata);
  assign w_we   = w_run & i_instr_valid & i_csr_wr_en & (|i_csr_op) & w_hit;
  assign w_mret = w_run & i_instr_valid & i_is_mret;
  // Recognition looks at the pre-write MIE/mie register values.
  assign w_ext  = r_meie & i_ext_irq;
  assign w_irq  = w_run & i_instr_valid & r_mie & (w_ext | (r_mtie & i_timer_irq));
  assign w_take = w_irq & ~i_is_mret;
  assign w_code = w_ext ? 4'd11 : 4'd7;
  assign w_vec  = {r_mtvec[31:2], 2'b00} + (r_mtvec[0] ? {26'b0, r_mcause[3:0], 2'b00} : 32'h0);

  always_comb begin
    w_state_nxt   = w_mret ? RET : w_take ? TRAP : RUN;
    o_redirect    = ~w_run;
    o_flush       = ~w_run;
    o_redirect_pc = r_state == TRAP ? w_vec : r_state == RET ? r_mepc : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= RESET_MTVEC & 32'hFFFF_FFFD;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mcycle   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcycle <= (w_we && i_csr_addr == 12'hB00) ? {r_mcycle[63:32], w_new} :
                  (w_we && i_csr_addr == 12'hB80) ? {w_new, r_mcycle[31:0]} : r_mcycle + 64'd1;
      if (w_take) begin
        r_mie  <= 1'b0;
        r_mpie <= r_mie;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_we && i_csr_addr == 12'h300) begin
        r_mie  <= w_new[3];
        r_mpie <= w_new[7];
      end
      if (w_we && i_csr_addr == 12'h304) begin
        r_mtie <= w_new[7];
        r_meie <= w_new[11];
      end
      if (w_we && i_csr_addr == 12'h305) r_mtvec <= w_new & 32'hFFFF_FFFD;
      if (w_we && i_csr_addr == 12'h340) r_mscratch <= w_new;
      // Trap entry overrides a same-cycle software write to mepc/mcause.
      if (w_take) r_mepc <= i_next_pc & 32'hFFFF_FFFC;
      else if (w_we && i_csr_addr == 12'h341) r_mepc <= w_new & 32'hFFFF_FFFC;
      if (w_take) r_mcause <= {1'b1, 27'b0, w_code};
      else if (w_we && i_csr_addr == 12'h342) r_mcause <= w_new;
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed stimulus for csr_unit, checked every cycle against a
// behavioural CSR/trap model plus hand-computed literal expectations.
module tb_csr_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 1'b0, rd_en = 1'b0, wr_en = 1'b0, mret = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [11:0] addr = 12'h0;
  logic [31:0] wdata = 32'h0, pc = 32'h0, next_pc = 32'h0;
  logic        timer_irq = 1'b0, ext_irq = 1'b0;
  logic [31:0] rdata, rpc;
  logic        illegal, redirect, flush;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  csr_unit #(.RESET_MTVEC(32'h0000_0100), .HART_ID(32'd5)) dut (
    .clk(clk), .rst_n(rst_n), .i_instr_valid(valid), .i_csr_rd_en(rd_en),
    .i_csr_wr_en(wr_en), .i_csr_op(op), .i_csr_addr(addr), .i_csr_wdata(wdata),
    .o_csr_rdata(rdata), .o_illegal_csr(illegal), .i_is_mret(mret), .i_pc(pc),
    .i_next_pc(next_pc), .i_timer_irq(timer_irq), .i_ext_irq(ext_irq),
    .o_redirect(redirect), .o_redirect_pc(rpc), .o_flush(flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural model: phase 0 = executing, 1 = trap redirect, 2 = mret redirect.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, wv;
  logic [63:0] m_cyc;
  int          m_phase, m_code;
  logic [32:0] rv;
  logic        run, old_mie, old_mpie, pend_e, take, cw;

  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, m_mstatus | 32'h1800};
      12'h304: return {1'b1, m_mie};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h344: return {1'b1, (32'(ext_irq) << 11) | (32'(timer_irq) << 7)};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hF14: return {1'b1, 32'd5};
      default: return 33'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_cyc = 0; m_phase = 0; m_code = 0;
    end
    rv  = mread(addr);
    run = m_phase == 0;
    check("model rdata", rdata, (run && rd_en && rv[32]) ? rv[31:0] : 32'h0);
    check("model illegal", 32'(illegal), 32'(run && (rd_en || wr_en) && !rv[32]));
    check("model redirect", 32'(redirect), 32'(!run));
    check("model flush", 32'(flush), 32'(!run));
    check("model redirect_pc", rpc,
          m_phase == 1 ? ((m_mtvec & 32'hFFFF_FFFC) + (m_mtvec[0] ? 32'(m_code) * 4 : 32'h0)) :
          m_phase == 2 ? m_mepc : 32'h0);
    if (rst_n) begin
      if (!run) begin
        m_phase = 0;
        m_cyc++;
      end else begin
        old_mie  = m_mstatus[3];
        old_mpie = m_mstatus[7];
        pend_e   = m_mie[11] && ext_irq;
        take     = valid && old_mie && (pend_e || (m_mie[7] && timer_irq));
        wv = op == 2'b01 ? wdata : op == 2'b10 ? (rv[31:0] | wdata) : (rv[31:0] & ~wdata);
        cw = 0;
        if (valid && wr_en && op != 2'b00 && rv[32])
          case (addr)
            12'h300: m_mstatus = wv & 32'h88;
            12'h304: m_mie = wv & 32'h880;
            12'h305: m_mtvec = wv & ~32'h2;
            12'h340: m_mscratch = wv;
            12'h341: m_mepc = wv & ~32'h3;
            12'h342: m_mcause = wv;
            12'hB00: begin m_cyc[31:0] = wv; cw = 1; end
            12'hB80: begin m_cyc[63:32] = wv; cw = 1; end
            default: ;
          endcase
        if (!cw) m_cyc++;
        if (valid && mret) begin
          m_mstatus = 32'h80 | (old_mpie ? 32'h8 : 32'h0);
          m_phase = 2;
        end else if (take) begin
          m_code    = pend_e ? 11 : 7;
          m_mepc    = next_pc & ~32'h3;
          m_mcause  = 32'h8000_0000 | 32'(m_code);
          m_mstatus = old_mie ? 32'h80 : 32'h0;
          m_phase   = 1;
        end
      end
    end
  end

  task automatic drive(input logic v, r, w, input logic [1:0] o, input logic [11:0] a,
                       input logic [31:0] d, input logic m, input logic [31:0] np,
                       input logic ti, input logic ei);
    @(posedge clk);
    #1;
    valid = v; rd_en = r; wr_en = w; op = o; addr = a; wdata = d; mret = m;
    next_pc = np; pc = np - 32'd4; timer_irq = ti; ext_irq = ei;
    @(negedge clk);
  endtask

  task automatic csr(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    drive(1, 1, 1, o, a, d, 0, 32'h1000, 0, 0);
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1, 1, 0, 2'b00, a, 0, 0, 32'h1000, 0, 0);
  endtask

  task automatic idle;
    drive(0, 0, 0, 2'b00, 12'h0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(12'h300); check("rst mstatus", rdata, 32'h1800);
    rd(12'h304); check("rst mie", rdata, 32'h0);
    rd(12'h305); check("rst mtvec", rdata, 32'h100);
    rd(12'h341); check("rst mepc", rdata, 32'h0);
    rd(12'h342); check("rst mcause", rdata, 32'h0);
    rd(12'hF14); check("mhartid", rdata, 32'd5);
    rd(12'hB80); check("rst mcycleh", rdata, 32'h0);
    csr(2'b01, 12'h344, 32'hFFFF_FFFF);
    rd(12'h344); check("mip after write", rdata, 32'h0);
    csr(2'b01, 12'h340, 32'hA5A5_A5A5); check("csrrw old", rdata, 32'h0);
    csr(2'b10, 12'h340, 32'h0F);        check("csrrs old", rdata, 32'hA5A5_A5A5);
    csr(2'b11, 12'h340, 32'hA0);        check("csrrc old", rdata, 32'hA5A5_A5AF);
    rd(12'h340); check("mscratch final", rdata, 32'hA5A5_A50F);
    rd(12'h7C0); check("illegal rd flag", 32'(illegal), 32'h1); check("illegal rdata", rdata, 32'h0);
    csr(2'b01, 12'h7C0, 32'hDEAD); check("illegal wr flag", 32'(illegal), 32'h1);
    rd(12'h340); check("mscratch after illegal", rdata, 32'hA5A5_A50F);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00); check("mcycle written", rdata, 32'hFFFF_FFFF);
    rd(12'hB00); check("mcycle wrapped", rdata, 32'h0);
    rd(12'hB80); check("mcycleh carry", rdata, 32'h1);
    csr(2'b01, 12'hB00, 32'd5);
    rd(12'hB00); check("mcycle write 5", rdata, 32'd5);
    // Timer interrupt, vectored mode
    csr(2'b01, 12'h305, 32'h201); check("mtvec old", rdata, 32'h100);
    csr(2'b01, 12'h304, 32'h80);
    csr(2'b10, 12'h300, 32'h8);   check("mstatus old", rdata, 32'h1800);
    drive(1, 0, 0, 2'b00, 12'h0, 0, 0, 32'h40, 1, 0); check("no redirect at T", 32'(redirect), 32'h0);
    drive(1, 1, 1, 2'b01, 12'h340, 32'h1234_5678, 0, 32'h44, 0, 0);
    check("trap redirect", 32'(redirect), 32'h1); check("trap flush", 32'(flush), 32'h1);
    check("trap vector", rpc, 32'h21C);
    rd(12'h341); check("mepc timer", rdata, 32'h40);
    rd(12'h342); check("mcause timer", rdata, 32'h8000_0007);
    rd(12'h300); check("mstatus in handler", rdata, 32'h1880);
    rd(12'h340); check("trap-cycle write ignored", rdata, 32'hA5A5_A50F);
    // Both pending: external wins; same-cycle mepc write is overridden
    csr(2'b01, 12'h304, 32'h880);
    csr(2'b10, 12'h300, 32'h8);
    drive(1, 1, 1, 2'b01, 12'h341, 32'h1234, 0, 32'h80, 1, 1); check("mepc old", rdata, 32'h40);
    idle; check("ext vector", rpc, 32'h22C);
    rd(12'h342); check("mcause ext", rdata, 32'h8000_000B);
    rd(12'h341); check("mepc trap wins", rdata, 32'h80);
    drive(1, 0, 0, 2'b00, 12'h0, 0, 1, 32'h300, 0, 0);
    idle; check("mret redirect", 32'(redirect), 32'h1); check("mret target", rpc, 32'h80);
    rd(12'h300); check("mstatus after mret", rdata, 32'h1888);
    // MRET and interrupt together: MRET wins, interrupt taken after return
    drive(1, 0, 0, 2'b00, 12'h0, 0, 1, 32'h300, 1, 0); check("mret beats irq", 32'(redirect), 32'h0);
    drive(1, 0, 0, 2'b00, 12'h0, 0, 0, 32'h84, 1, 0); check("ret target", rpc, 32'h80);
    drive(1, 0, 0, 2'b00, 12'h0, 0, 0, 32'h90, 1, 0); check("irq after ret", 32'(redirect), 32'h0);
    idle; check("second trap vector", rpc, 32'h21C);
    #2 rst_n = 1'b0;
    #1 check("async rst redirect", 32'(redirect), 32'h0);
    check("async rst flush", 32'(flush), 32'h0);
    check("async rst pc", rpc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(12'h305); check("mtvec after rst", rdata, 32'h100);
    rd(12'h300); check("mstatus after rst", rdata, 32'h1800);
    idle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control and status register file with interrupt and trap sequencing for the single-cycle RV32I core. It sits directly downstream of the instruction controller. It consumes the controller's CSR read/write enables, the CSR operation and the MRET indication, and returns CSR read data for writeback. It also owns interrupt recognition and drives the PC-redirect and flush signals used for trap entry and MRET return.

## Interface
Parameters:
- RESET_MTVEC, 32'h0000_0100, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  the current instruction is live this cycle.
- csr_rd_en  input  1  CSR read request from the controller.
- csr_wr_en  input  1  CSR write request from the controller.
- csr_op  input  2  01 = RW, 10 = RS, 11 = RC, 00 = no write (funct3[1:0]).
- csr_addr  input  12  CSR address (instr[31:20]).
- csr_wdata  input  32  rs1 value, or zero-extended zimm.
- csr_rdata  output  32  old CSR value, combinational.
- illegal_csr  output  1  an access targets an unimplemented address.
- is_mret  input  1  the current instruction is MRET.
- pc  input  32  PC of the current instruction.
- next_pc  input  32  PC the core will fetch next if there is no trap.
- timer_irq  input  1  level-sensitive machine timer interrupt.
- ext_irq  input  1  level-sensitive machine external interrupt.
- redirect  output  1  the core must load redirect_pc this cycle.
- redirect_pc  output  32  trap vector or mepc.
- flush  output  1  the core suppresses rf/mem/CSR writes of the current instruction.

## Operation
Implemented CSRs:
- mstatus 0x300: MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
- mie 0x304: MTIE[7] and MEIE[11] are writable; all other bits read 0.
- mtvec 0x305: BASE[31:2] and MODE[0] are writable; bit 1 is hardwired to 0. MODE 0 = direct, 1 = vectored.
- mscratch 0x340: full 32 bits writable.
- mepc 0x341: bits [1:0] are hardwired to 0.
- mcause 0x342: full 32 bits writable.
- mip 0x344: reads MTIP[7] = timer_irq and MEIP[11] = ext_irq; writes are ignored.
- mcycle 0xB00 / mcycleh 0xB80: a 64-bit counter.
- mhartid 0xF14: read-only, returns HART_ID.

Reads and writes:
- csr_rdata is the pre-write value. It is 0 when csr_rd_en = 0 or the address is unimplemented.
- The write value depends on csr_op: RW gives wdata, RS gives old | wdata, RC gives old & ~wdata. The write commits on the clock edge when csr_wr_en & instr_valid & state = RUN & csr_op != 00.
- An unimplemented address with rd_en or wr_en asserts illegal_csr combinationally. Such accesses cause no state change.

mcycle:
- The counter increments every cycle, including in the TRAP and RET states.
- A software write to either half takes precedence over the increment in that cycle, for the full 64 bits.

Interrupt recognition:
- irq_take = instr_valid & state = RUN & mstatus.MIE & ((MEIE & ext_irq) | (MTIE & timer_irq)).
- Recognition uses the MIE and mie values before any write in the same cycle.
- External interrupts have priority over timer interrupts. Cause codes are 11 and 7.

FSM states: RUN, TRAP, RET.
- RUN with is_mret & instr_valid: go to RET. At the edge, MIE <= MPIE and MPIE <= 1.
- RUN with irq_take and no MRET: the instruction in this cycle retires normally. At the edge:
  - go to TRAP;
  - mepc <= next_pc;
  - mcause <= {1'b1, 27'b0, code};
  - MPIE <= MIE and MIE <= 0.
  - A same-cycle CSR write to mstatus, mepc or mcause is overridden by these trap updates. Writes to any other CSR still commit.
- MRET and irq_take in the same cycle: MRET wins. The interrupt is re-evaluated in RUN after the return, with MIE restored.
- TRAP: redirect = 1 and flush = 1 for one cycle.
  - redirect_pc = BASE in direct mode, or BASE + 4*code in vectored mode.
  - Always return to RUN.
- RET: redirect = 1, flush = 1 and redirect_pc = mepc. Always return to RUN.
- In TRAP and RET, instr_valid, the CSR inputs and is_mret are ignored.
- redirect and flush are 0 in RUN.

Reset values:
- mstatus, mie, mscratch, mepc, mcause and mcycle reset to 0.
- mtvec resets to RESET_MTVEC.
- The FSM resets to RUN, with redirect = 0, flush = 0 and redirect_pc = 0.
- Reset asserted mid-TRAP or mid-RET aborts the redirect immediately (asynchronously).

## Timing
- csr_rdata and illegal_csr: 0-cycle (combinational) latency.
- CSR writes are visible to a read in the next cycle.
- Interrupt latency: the interrupt is recognized in cycle T, and redirect is asserted in T+1. The first handler instruction is fetched in T+2.
- MRET: decoded in cycle T, redirect to mepc in T+1.
- The interrupt inputs are level-sensitive and sampled each cycle. They are not latched.

## Test plan
- Reset, then read every CSR: all read 0, except mtvec = 0x100, mstatus = 0x1800 and mhartid = HART_ID. Writing 0xFFFF_FFFF to mip leaves it reading 0 while both IRQ inputs are low.
- CSRRW mscratch 0xA5A5_A5A5, then CSRRS with 0x0F, then CSRRC with 0xA0: the reads return 0, 0xA5A5_A5A5 and 0xA5A5_A5AF in turn, and the final value is 0xA5A5_A50F.
- mtvec = 0x201 (vectored), MIE = 1, MTIE = 1, timer_irq raised with next_pc = 0x40:
  - next cycle: redirect = 1, flush = 1, redirect_pc = 0x21C;
  - mepc = 0x40, mcause = 0x8000_0007, MIE = 0, MPIE = 1.
- Both IRQs are pending with MEIE = MTIE = 1: cause 0x8000_000B is taken. MRET then gives redirect_pc = mepc, MIE = 1 and MPIE = 1.
- A CSRRW to mepc in the interrupt-recognition cycle: the trap value next_pc wins.
- A read of unimplemented address 0x7C0: illegal_csr = 1, csr_rdata = 0, no state change.
- mcycle counting: mcycle = 0x0000_0000 and mcycleh = 0x0000_0001 after writing mcycle = 0xFFFF_FFFF. Writing mcycle = 5 reads back 5 in the next cycle, with no increment in the write cycle.
